// File: rtl/mpu6050_burst_reader.sv
// I2C master that repeatedly burst-reads NUM_WORDS big-endian 16-bit registers
// from an MPU6050-class sensor and flags words whose magnitude exceeds THRESH.
module mpu6050_burst_reader #(
    parameter int unsigned CLK_DIV   = 62,
    parameter logic [6:0]  DEV_ADDR  = 7'h68,
    parameter logic [7:0]  START_REG = 8'h3B,
    parameter int unsigned NUM_WORDS = 3,
    parameter logic [15:0] THRESH    = 16'd4000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_sensor,
    inout  logic                      SDA_BUS,
    output logic                      SCL_BUS,
    output logic [16*NUM_WORDS-1:0]   data_out,
    output logic                      data_valid,
    output logic                      busy,
    output logic                      ack_error,
    output logic [NUM_WORDS-1:0]      mover
);

    localparam int unsigned QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned NBYTES = 2 * NUM_WORDS;
    localparam int unsigned BW     = $clog2(NBYTES);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_RSTART,
        S_ADDR_R, S_ACK3, S_READ, S_MACK, S_STOP, S_GAP
    } state_t;

    state_t                    state, state_next;
    logic [QW-1:0]             qcnt;
    logic [1:0]                quarter;
    logic [2:0]                bit_cnt;
    logic [BW-1:0]             byte_idx;
    logic [7:0]                rx_byte;
    logic [7:0]                tx_byte;
    logic                      sda_smp;
    logic [16*NUM_WORDS-1:0]   shadow;
    logic [NUM_WORDS-1:0]      mover_next;
    logic [15:0]               word;
    logic [16:0]               mag;
    logic [BW+2:0]             sh_base;
    logic                      tick, slot_end;
    logic                      scl, sda_low;

    assign tick     = (qcnt == QW'(CLK_DIV - 1));
    assign slot_end = tick && (quarter == 2'd3);
    // Byte k of the burst lands high-then-low within word k/2.
    assign sh_base  = {byte_idx ^ BW'(1), 3'b000};

    assign SCL_BUS = scl;
    assign SDA_BUS = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        tx_byte = '0;
        case (state)
            S_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
            S_REG:    tx_byte = START_REG;
            S_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
            default:  tx_byte = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        scl        = 1'b1;
        sda_low    = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (tick && enable_sensor) state_next = S_START;
            end
            S_START: begin
                sda_low = quarter[1];
                if (slot_end) state_next = S_ADDR_W;
            end
            S_ADDR_W, S_REG, S_ADDR_R: begin
                scl     = quarter[1];
                sda_low = ~tx_byte[3'd7 - bit_cnt];
                if (slot_end && bit_cnt == 3'd7) begin
                    if (state == S_ADDR_W)   state_next = S_ACK1;
                    else if (state == S_REG) state_next = S_ACK2;
                    else                     state_next = S_ACK3;
                end
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                scl = quarter[1];
                if (slot_end) begin
                    if (sda_smp)              state_next = S_STOP;
                    else if (state == S_ACK1) state_next = S_REG;
                    else if (state == S_ACK2) state_next = S_RSTART;
                    else                      state_next = S_READ;
                end
            end
            S_RSTART: begin
                scl     = (quarter != 2'd0);
                sda_low = quarter[1];
                if (slot_end) state_next = S_ADDR_R;
            end
            S_READ: begin
                scl = quarter[1];
                if (slot_end && bit_cnt == 3'd7) state_next = S_MACK;
            end
            S_MACK: begin
                scl     = quarter[1];
                sda_low = (byte_idx != LAST_BYTE);
                if (slot_end) state_next = (byte_idx == LAST_BYTE) ? S_STOP : S_READ;
            end
            S_STOP: begin
                scl     = (quarter != 2'd0);
                sda_low = ~quarter[1];
                if (slot_end) state_next = S_GAP;
            end
            S_GAP: begin
                // Three quarters here plus the IDLE quarter make one idle bit slot.
                busy = 1'b0;
                if (tick && quarter == 2'd2) state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mover_next = '0;
        word       = '0;
        mag        = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            word          = shadow[16*i +: 16];
            mag           = word[15] ? (~{1'b1, word}) + 17'd1 : {1'b0, word};
            mover_next[i] = (mag > {1'b0, THRESH});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt       <= '0;
            quarter    <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            rx_byte    <= '0;
            sda_smp    <= 1'b0;
            shadow     <= '0;
            data_out   <= '0;
            mover      <= '0;
            data_valid <= 1'b0;
            ack_error  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            qcnt       <= tick ? '0 : qcnt + QW'(1);
            if (tick) begin
                if (state == S_IDLE || state_next != state) quarter <= 2'd0;
                else                                        quarter <= quarter + 2'd1;
                if (quarter == 2'd2) begin
                    sda_smp <= SDA_BUS;
                    if (state == S_READ) rx_byte <= {rx_byte[6:0], SDA_BUS};
                end
                if (state == S_IDLE && enable_sensor) begin
                    ack_error <= 1'b0;
                    bit_cnt   <= '0;
                    byte_idx  <= '0;
                end
                if (slot_end) begin
                    case (state)
                        S_ADDR_W, S_REG, S_ADDR_R: bit_cnt <= bit_cnt + 3'd1;
                        S_READ: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) shadow[sh_base +: 8] <= rx_byte;
                        end
                        S_MACK: byte_idx <= byte_idx + BW'(1);
                        S_ACK1, S_ACK2, S_ACK3: if (sda_smp) ack_error <= 1'b1;
                        S_STOP: begin
                            if (!ack_error) begin
                                data_valid <= 1'b1;
                                data_out   <= shadow;
                                mover      <= mover_next;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_burst_reader.sv
// Bench for mpu6050_burst_reader: behavioural I2C slave, table of bursts with
// randomized register contents, plus hand sequences for reset, enable drop and gap timing.
module tb_mpu6050_burst_reader;

    localparam int unsigned CDIV = 4;
    localparam int unsigned SLOT = 4 * CDIV;
    localparam int unsigned TXN  = 85 * SLOT;
    localparam int unsigned NV   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_sensor;
    wire         SDA_BUS;
    logic        SCL_BUS;
    logic [47:0] data_out;
    logic        data_valid, busy, ack_error;
    logic [2:0]  mover;
    logic        slv_drv = 1'b0;

    always #5 clk = ~clk;

    pullup (SDA_BUS);
    assign SDA_BUS = slv_drv ? 1'b0 : 1'bz;

    mpu6050_burst_reader #(
        .CLK_DIV(CDIV), .DEV_ADDR(7'h68), .START_REG(8'h3B),
        .NUM_WORDS(3), .THRESH(16'd4000)
    ) dut (
        .clk(clk), .reset(reset), .enable_sensor(enable_sensor),
        .SDA_BUS(SDA_BUS), .SCL_BUS(SCL_BUS), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .ack_error(ack_error), .mover(mover)
    );

    typedef struct packed {
        logic [47:0] resp;
        logic        nack;
        logic [47:0] exp_data;
        logic [2:0]  exp_mover;
        logic        exp_valid;
    } vec_t;

    vec_t tbl [NV];
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- behavioural I2C slave ----------------
    logic [47:0] cur_resp;
    logic        cur_nack;
    logic        pscl = 1'b1, psda = 1'b1, scl_s, sda_s;
    logic        active = 1'b0, reading = 1'b0, go_read = 1'b0, is_addr = 1'b0, done = 1'b0;
    logic [7:0]  shin, slv_rb;
    int          bitn, ridx;
    logic [23:0] wshift;
    int          wcount;
    logic [5:0]  mshift;
    int          mcount;

    always @(posedge clk) begin
        scl_s = SCL_BUS;
        sda_s = SDA_BUS;
        if (!reset) begin
            active = 1'b0; reading = 1'b0; go_read = 1'b0; slv_drv = 1'b0;
            pscl = 1'b1; psda = 1'b1;
        end else begin
            if (scl_s && pscl && psda && !sda_s) begin
                active = 1'b1; bitn = -1; reading = 1'b0; go_read = 1'b0;
                is_addr = 1'b1; done = 1'b0; ridx = 0;
            end else if (scl_s && pscl && !psda && sda_s) begin
                active = 1'b0; slv_drv = 1'b0;
            end else if (active && scl_s && !pscl) begin
                if (bitn >= 0 && bitn < 8) shin = {shin[6:0], sda_s};
                else if (bitn == 8 && reading) begin
                    mshift = {mshift[4:0], sda_s};
                    mcount++;
                    if (sda_s) done = 1'b1;
                    else       ridx++;
                end
            end else if (active && !scl_s && pscl) begin
                bitn++;
                if (bitn == 9) bitn = 0;
                if (bitn == 8) begin
                    if (reading) slv_drv = 1'b0;
                    else begin
                        wshift = {wshift[15:0], shin};
                        wcount++;
                        slv_drv = !(cur_nack && is_addr && !shin[0]);
                        if (slv_drv && is_addr && shin[0]) go_read = 1'b1;
                        is_addr = 1'b0;
                    end
                end else begin
                    if (bitn == 0 && go_read) begin reading = 1'b1; go_read = 1'b0; end
                    if (reading && !done) begin
                        slv_rb  = 8'(cur_resp >> (8 * (5 - ridx)));
                        slv_drv = !slv_rb[7 - bitn];
                    end else slv_drv = 1'b0;
                end
            end
            pscl = scl_s;
            psda = sda_s;
        end
    end

    // ---------------- event monitor ----------------
    int   cyc = 0, dv_cnt = 0, dv_last = 0, rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
    logic pbusy = 1'b0, idle_scl_low = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (data_valid) begin dv_cnt++; dv_last = cyc; end
        if (busy && !pbusy) begin rise_cnt++; rise_cyc = cyc; end
        if (!busy && pbusy) fall_cyc = cyc;
        if (!busy && !SCL_BUS) idle_scl_low = 1'b1;
        pbusy = busy;
    end

    // ---------------- reference model ----------------
    function automatic logic [47:0] model_data(input logic [47:0] r);
        logic [47:0] d;
        for (int i = 0; i < 3; i++) d[16*i +: 16] = 16'(r >> (32 - 16 * i));
        return d;
    endfunction

    function automatic logic [2:0] model_mover(input logic [47:0] r);
        logic [2:0] m;
        for (int i = 0; i < 3; i++) begin
            int w, s;
            w    = int'(16'(r >> (32 - 16 * i)));
            s    = (w >= 32768) ? w - 65536 : w;
            m[i] = ((s < 0) ? -s : s) > 4000;
        end
        return m;
    endfunction

    function automatic logic [15:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h0FA0;
            2: return 16'hF060;
            3: return 16'h0FA1;
            4: return 16'hF05F;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n = 0;
        while (busy !== lvl && n < bound) begin @(negedge clk); n++; end
        if (busy !== lvl) begin
            vectors++; miscompares++;
            $display("FAIL %s: got timeout expected busy=%0d", name, lvl);
        end
    endtask

    task automatic set_stim(input logic [47:0] r, input logic nk);
        cur_resp = r; cur_nack = nk;
        wshift = '0; wcount = 0; mshift = '0; mcount = 0;
    endtask

    task automatic count_to_start(input string name);
        int n = 0;
        while (n < 4 * CDIV) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (busy) break;
        end
        check(name, 64'(n), 64'(CDIV));
    endtask

    initial begin
        logic [47:0] pd, r;
        logic [2:0]  pm;
        logic        nk;
        int          dv0, t1, rs;

        reset = 1'b0; enable_sensor = 1'b0;
        tbl[0] = '{48'h1000F0000020, 1'b0, 48'h0020F0001000, 3'b011, 1'b1};
        tbl[1] = '{48'h80000FA0F060, 1'b0, 48'hF0600FA08000, 3'b001, 1'b1};
        tbl[2] = '{48'h123456789ABC, 1'b1, 48'hF0600FA08000, 3'b001, 1'b0};
        tbl[3] = '{48'h7FFF0000F05F, 1'b0, 48'hF05F00007FFF, 3'b101, 1'b1};
        pd = tbl[3].exp_data; pm = tbl[3].exp_mover;
        for (int i = 4; i < NV; i++) begin
            r  = {pick_word(), pick_word(), pick_word()};
            nk = (i != NV - 1) && ($urandom_range(0, 3) == 0);
            if (!nk) begin pd = model_data(r); pm = model_mover(r); end
            tbl[i] = '{r, nk, pd, pm, !nk};
        end

        set_stim(tbl[0].resp, tbl[0].nack);
        repeat (3) @(negedge clk);
        check("rst_scl", 64'(SCL_BUS), 64'd1);
        check("rst_sda", 64'(SDA_BUS), 64'd1);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_mover", 64'(mover), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_ackerr", 64'(ack_error), 64'd0);

        @(negedge clk);
        reset = 1'b1; enable_sensor = 1'b1;
        count_to_start("first_start_latency");

        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                set_stim(tbl[i].resp, tbl[i].nack);
                wait_busy(1'b1, 4 * SLOT, "vec_start");
            end
            dv0 = dv_cnt;
            wait_busy(1'b0, TXN + SLOT, "vec_end");
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 64'(dv_cnt - dv0), 64'(tbl[i].exp_valid));
            check($sformatf("v%0d_data", i), 64'(data_out), 64'(tbl[i].exp_data));
            check($sformatf("v%0d_mover", i), 64'(mover), 64'(tbl[i].exp_mover));
            check($sformatf("v%0d_ackerr", i), 64'(ack_error), 64'(tbl[i].nack));
            check($sformatf("v%0d_wbytes", i), 64'(wshift), tbl[i].nack ? 64'h0000D0 : 64'hD03BD1);
            check($sformatf("v%0d_wcount", i), 64'(wcount), tbl[i].nack ? 64'd1 : 64'd3);
            check($sformatf("v%0d_mack", i), 64'(mshift), tbl[i].nack ? 64'd0 : 64'b000001);
            check($sformatf("v%0d_mcount", i), 64'(mcount), tbl[i].nack ? 64'd0 : 64'd6);
        end

        // back-to-back bursts: idle gap and data_valid spacing
        t1 = dv_last;
        r  = {pick_word(), pick_word(), pick_word()};
        set_stim(r, 1'b0);
        wait_busy(1'b1, 4 * SLOT, "b2b_start");
        @(negedge clk);
        check("b2b_gap", 64'(rise_cyc - fall_cyc), 64'(SLOT));
        wait_busy(1'b0, TXN + SLOT, "b2b_end");
        @(negedge clk);
        check("b2b_valid_spacing", 64'(dv_last - t1), 64'(TXN));
        check("b2b_data", 64'(data_out), 64'(model_data(r)));
        check("b2b_mover", 64'(mover), 64'(model_mover(r)));

        // enable dropped during the third byte
        r = {pick_word(), pick_word(), pick_word()};
        set_stim(r, 1'b0);
        wait_busy(1'b1, 4 * SLOT, "drop_start");
        dv0 = dv_cnt;
        repeat (22 * SLOT) @(negedge clk);
        enable_sensor = 1'b0;
        wait_busy(1'b0, TXN + SLOT, "drop_end");
        @(negedge clk);
        check("drop_valid", 64'(dv_cnt - dv0), 64'd1);
        check("drop_data", 64'(data_out), 64'(model_data(r)));
        rs = rise_cnt;
        repeat (10 * SLOT) @(negedge clk);
        check("drop_no_restart", 64'(rise_cnt - rs), 64'd0);
        check("drop_busy", 64'(busy), 64'd0);

        // reset in the middle of a transaction
        r = {pick_word(), pick_word(), pick_word()};
        set_stim(r, 1'b0);
        enable_sensor = 1'b1;
        wait_busy(1'b1, 4 * SLOT, "mrst_start");
        repeat (5 * CDIV) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mrst_scl", 64'(SCL_BUS), 64'd1);
        check("mrst_sda", 64'(SDA_BUS), 64'd1);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_data", 64'(data_out), 64'd0);
        check("mrst_mover", 64'(mover), 64'd0);
        check("mrst_valid", 64'(data_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_to_start("mrst_restart_latency");
        enable_sensor = 1'b0;
        wait_busy(1'b0, TXN + SLOT, "mrst_end");
        @(negedge clk);
        check("mrst_after_data", 64'(data_out), 64'(model_data(r)));
        check("mrst_after_mover", 64'(mover), 64'(model_mover(r)));
        check("idle_scl_high", 64'(idle_scl_low), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
